cs_word_queue: RTL and testbench



---
 rtl/cs_pkg.sv | 19 +
 rtl/cs_word_ram.sv | 25 ++
 rtl/cs_word_queue.sv | 109 ++++++++++
 tb/tb_cs_word_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared control-word constants for the sequencer / field-mapper path.
package cs_pkg;

   localparam int unsigned CW_WIDTH_DEFAULT = 59;

   // Bit positions of fields inside a control word.
   localparam int unsigned CS_DB_NREAD_BIT  = 30;
   localparam int unsigned CS_DB_NWRITE_BIT = 2;
   localparam int unsigned CS_CU_ADV_LSB    = 28;

   // Idle word: both active-low bus strobes deasserted, every other field zero.
   localparam logic [CW_WIDTH_DEFAULT-1:0] CS_NOP_WORD = 59'h0000_0000_4000_0004;

   // True when a word leaves both bus strobes deasserted.
   function automatic logic cs_strobes_idle(input logic [CW_WIDTH_DEFAULT-1:0] word);
      return word[CS_DB_NREAD_BIT] && word[CS_DB_NWRITE_BIT];
   endfunction

endpackage

// File: rtl/cs_word_ram.sv
// DEPTH x CW_WIDTH register array: one synchronous write port, one asynchronous read port.
module cs_word_ram #(
   parameter int unsigned CW_WIDTH = 59,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [CW_WIDTH-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [CW_WIDTH-1:0]        rdata
);

   logic [CW_WIDTH-1:0] r_mem [DEPTH];

   // Storage write; contents are not reset, validity is tracked by the queue pointers.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/cs_word_queue.sv
// Control-word queue between the microcode sequencer and the field mapper.
// Substitutes the NOP word whenever no real word is at the head.
module cs_word_queue
   import cs_pkg::*;
#(
   parameter int unsigned          CW_WIDTH = CW_WIDTH_DEFAULT,
   parameter int unsigned          DEPTH    = 4,
   parameter logic [CW_WIDTH-1:0]  NOP_WORD = CW_WIDTH'(CS_NOP_WORD),
   parameter bit                   BYPASS   = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CW_WIDTH-1:0]        in_word,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [CW_WIDTH-1:0]        out_word,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count,
   output logic [$clog2(DEPTH):0]     hwm
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    r_hwm;

   logic                w_full;
   logic                w_empty;
   logic                w_bypass_hit;
   logic                w_push;
   logic                w_pop;
   logic                w_we;
   logic                w_rd_adv;
   logic [CNT_W-1:0]    w_count_d;
   logic [CNT_W-1:0]    w_hwm_d;
   logic [CW_WIDTH-1:0] w_rdata;

   cs_word_ram #(
      .CW_WIDTH (CW_WIDTH),
      .DEPTH    (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (w_we),
      .waddr (r_wr_ptr),
      .wdata (in_word),
      .raddr (r_rd_ptr),
      .rdata (w_rdata)
   );

   // Handshake decode, bypass detection and head-word selection.
   always_comb begin
      w_full       = (r_count == FULL_CNT);
      w_empty      = (r_count == '0);
      w_bypass_hit = BYPASS && w_empty && in_valid;
      in_ready     = !w_full && !flush;
      out_valid    = !flush && (!w_empty || w_bypass_hit);
      w_push       = in_valid && in_ready;
      w_pop        = out_valid && out_ready;
      // A bypassed word consumed in the same cycle is never stored.
      w_we         = w_push && !(w_empty && w_pop) && !rst;
      w_rd_adv     = w_pop && !w_empty;
      if (!out_valid) begin
         out_word = NOP_WORD;
      end else if (w_empty) begin
         out_word = in_word;
      end else begin
         out_word = w_rdata;
      end
   end

   // Next occupancy and high-water mark.
   always_comb begin
      w_count_d = r_count + CNT_W'(w_we) - CNT_W'(w_rd_adv);
      w_hwm_d   = (w_count_d > r_hwm) ? w_count_d : r_hwm;
   end

   // Pointer, occupancy and high-water-mark registers; flush keeps the high-water mark.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_hwm    <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_we) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_rd_adv) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_d;
         r_hwm   <= w_hwm_d;
      end
   end

   assign count = r_count;
   assign hwm   = r_hwm;

endmodule

// File: tb/tb_cs_word_queue.sv
// Bench for cs_word_queue: one BYPASS=0 and one BYPASS=1 instance on shared stimulus,
// each compared every cycle against a queue-based reference model.
module tb_cs_word_queue;
   import cs_pkg::*;

   localparam int unsigned W  = 59;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  in_word;
   logic          in_valid;
   logic          out_ready;
   logic          flush;

   logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [W-1:0]  a_out_word, b_out_word;
   logic [CW-1:0] a_count, a_hwm, b_count, b_hwm;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one word queue and one high-water mark per instance.
   logic [W-1:0] mq [2][$];
   int           mhwm [2];

   always #5 clk = ~clk;

   cs_word_queue #(.CW_WIDTH(W), .DEPTH(D), .NOP_WORD(CS_NOP_WORD), .BYPASS(1'b0)) u_dut (
      .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(a_in_ready),
      .out_word(a_out_word), .out_valid(a_out_valid), .out_ready(out_ready), .flush(flush),
      .count(a_count), .hwm(a_hwm)
   );

   cs_word_queue #(.CW_WIDTH(W), .DEPTH(D), .NOP_WORD(CS_NOP_WORD), .BYPASS(1'b1)) u_dut_byp (
      .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(b_in_ready),
      .out_word(b_out_word), .out_valid(b_out_valid), .out_ready(out_ready), .flush(flush),
      .count(b_count), .hwm(b_hwm)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle, compare outputs against the model, then advance the model over the edge.
   task automatic step(input logic r, input logic iv, input logic [W-1:0] iw,
                       input logic ordy, input logic fl);
      bit           empty, e_rdy, e_ov, push, pop;
      logic [W-1:0] e_ow;
      rst = r; in_valid = iv; in_word = iw; out_ready = ordy; flush = fl;
      #2;
      for (int k = 0; k < 2; k++) begin
         empty = (mq[k].size() == 0);
         e_rdy = (mq[k].size() < D) && !fl;
         e_ov  = !fl && (!empty || (k == 1 && iv));
         e_ow  = !e_ov ? CS_NOP_WORD : (empty ? iw : mq[k][0]);
         if (k == 0) begin
            check("A.in_ready",  64'(a_in_ready),  64'(e_rdy));
            check("A.out_valid", 64'(a_out_valid), 64'(e_ov));
            check("A.out_word",  64'(a_out_word),  64'(e_ow));
            check("A.count",     64'(a_count),     64'(mq[k].size()));
            check("A.hwm",       64'(a_hwm),       64'(mhwm[k]));
         end else begin
            check("B.in_ready",  64'(b_in_ready),  64'(e_rdy));
            check("B.out_valid", 64'(b_out_valid), 64'(e_ov));
            check("B.out_word",  64'(b_out_word),  64'(e_ow));
            check("B.count",     64'(b_count),     64'(mq[k].size()));
            check("B.hwm",       64'(b_hwm),       64'(mhwm[k]));
         end
         if (r) begin
            mq[k].delete();
            mhwm[k] = 0;
         end else if (fl) begin
            mq[k].delete();
         end else begin
            push = iv && e_rdy;
            pop  = e_ov && ordy;
            if (!(empty && push && pop)) begin
               if (pop) void'(mq[k].pop_front());
               if (push) mq[k].push_back(iw);
            end
            if (mq[k].size() > mhwm[k]) mhwm[k] = mq[k].size();
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_sample();
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [63:0] r64;
      mhwm[0] = 0; mhwm[1] = 0;
      rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset then idle.
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      check("rst.out_word", 64'(a_out_word), 64'h0000_0000_4000_0004);
      check("rst.hwm", 64'(a_hwm), 64'd0);

      // Fill to full, attempt a fifth push, then drain in order.
      for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, W'(i), 1'b0, 1'b0);
      check("full.count", 64'(a_count), 64'd4);
      check("full.in_ready", 64'(a_in_ready), 64'd0);
      check("full.hwm", 64'(a_hwm), 64'd4);
      step(1'b0, 1'b1, W'(5), 1'b1, 1'b0);  // full: push refused even with out_ready
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("drain.count", 64'(a_count), 64'd0);
      check("drain.nop", 64'(cs_strobes_idle(a_out_word)), 64'd1);

      // Wrap-around with simultaneous push/pop at count 2.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b1, W'(16), 1'b0, 1'b0);
      step(1'b0, 1'b1, W'(17), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, W'(32 + i), 1'b1, 1'b0);
      check("wrap.count", 64'(a_count), 64'd2);
      idle_sample();

      // Flush at count 3 with a push in the same cycle.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(64 + i), 1'b0, 1'b0);
      step(1'b0, 1'b1, W'(99), 1'b1, 1'b1);
      check("flush.count", 64'(a_count), 64'd0);
      check("flush.out_valid", 64'(a_out_valid), 64'd0);
      check("flush.hwm", 64'(a_hwm), 64'd3);
      idle_sample();

      // Bypass: consumed in the same cycle, then stored when not consumed.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b1, W'(8'h7F), 1'b1, 1'b0);
      check("byp.count0", 64'(b_count), 64'd0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b1, W'(8'h7F), 1'b0, 1'b0);
      check("byp.count1", 64'(b_count), 64'd1);
      idle_sample();

      // Reset mid-stream at count 2 during push+pop.
      step(1'b0, 1'b1, W'(200), 1'b0, 1'b0);
      step(1'b1, 1'b1, W'(201), 1'b1, 1'b0);
      check("rst2.count", 64'(a_count), 64'd0);
      check("rst2.out_valid", 64'(a_out_valid), 64'd0);
      check("rst2.bit30", 64'(a_out_word[30]), 64'd1);
      check("rst2.bit2", 64'(a_out_word[2]), 64'd1);
      idle_sample();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         r64 = {$urandom(), $urandom()};
         step(($urandom_range(99) < 2), ($urandom_range(99) < 60), r64[W-1:0],
              ($urandom_range(99) < 45), ($urandom_range(99) < 4));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
